// File: rtl/spwm_duty_decoder.sv
// spwm_duty_decoder
//   Reads back the three-phase SPWM gate signals and measures, per carrier period (sync to
//   sync), the high time of each phase and the period length. This recovers the sampled sine
//   reference for loop-back self-test and closed-loop monitoring. Same clock domain as the
//   modulator.
//
//   Optional feature macro: PWM_COMPL_CHECK_EN
//     defined   : complementary-pair checker drives sticky fault flags
//     undefined : fault tied to 3'b000, Van/Vbn/Vcn unused
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   sync         in   1-cycle pulse at carrier period start
//   Va, Vb, Vc   in   high-side gate signals
//   Van,Vbn,Vcn  in   complementary gate signals
//   duty_a/b/c   out  high-time count of each phase over last complete period
//   period       out  length in clk cycles of last complete period
//   valid        out  1-cycle strobe when duty_x/period update
//   timeout      out  no sync within PERIOD_MAX cycles
//   fault        out  {c,b,a} sticky complement-violation flags
module spwm_duty_decoder #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD_MAX = 16'hFFFF,
  parameter int unsigned FAULT_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic             Va,
  input  logic             Vb,
  input  logic             Vc,
  input  logic             Van,
  input  logic             Vbn,
  input  logic             Vcn,
  output logic [CNT_W-1:0] duty_a,
  output logic [CNT_W-1:0] duty_b,
  output logic [CNT_W-1:0] duty_c,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic [2:0]       fault
);

  localparam logic [CNT_W-1:0] PerMax = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StTimeout
  } state_e;

  state_e                  state_q;
  logic                    sync_q;
  logic [2:0]              v_q;
  logic [CNT_W-1:0]        per_cnt_q;
  logic [2:0][CNT_W-1:0]   hi_q;
  logic [2:0][CNT_W-1:0]   duty_q;
  logic [CNT_W-1:0]        period_q;
  logic                    valid_q;
  logic                    timeout_q;

  // Window-start and accumulate values for the per-phase high-time counters.
  logic [2:0][CNT_W-1:0]   hi_start;
  logic [2:0][CNT_W-1:0]   hi_inc;

  always_comb begin
    hi_start = '0;
    hi_inc   = '0;
    for (int i = 0; i < 3; i++) begin
      hi_start[i] = CNT_W'(v_q[i]);
      hi_inc[i]   = hi_q[i] + CNT_W'(v_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync_q    <= 1'b0;
      v_q       <= '0;
      per_cnt_q <= '0;
      hi_q      <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q  <= sync;
      v_q     <= {Vc, Vb, Va};
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // First sync only opens a window; nothing complete to report yet.
          if (sync_q) begin
            state_q   <= StMeasure;
            per_cnt_q <= CntOne;
            hi_q      <= hi_start;
          end
        end
        StMeasure: begin
          // Sync takes priority over the timeout check so a period of exactly
          // PERIOD_MAX still reports normally.
          if (sync_q) begin
            duty_q    <= hi_q;
            period_q  <= per_cnt_q;
            valid_q   <= 1'b1;
            per_cnt_q <= CntOne;
            hi_q      <= hi_start;
          end else if (per_cnt_q == PerMax) begin
            state_q   <= StTimeout;
            timeout_q <= 1'b1;
          end else begin
            per_cnt_q <= per_cnt_q + CntOne;
            hi_q      <= hi_inc;
          end
        end
        StTimeout: begin
          // The window interrupted by the timeout is incomplete: restart silently.
          if (sync_q) begin
            state_q   <= StMeasure;
            timeout_q <= 1'b0;
            per_cnt_q <= CntOne;
            hi_q      <= hi_start;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign duty_a  = duty_q[0];
  assign duty_b  = duty_q[1];
  assign duty_c  = duty_q[2];
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

`ifdef PWM_COMPL_CHECK_EN
  localparam int unsigned ZcW = $clog2(FAULT_CYC + 1);
  localparam logic [ZcW-1:0] ZcLast = ZcW'(FAULT_CYC - 1);

  logic [2:0]          vn_q;
  // Count of preceding consecutive both-low cycles per phase.
  logic [2:0][ZcW-1:0] zc_q;
  logic [2:0]          fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vn_q    <= '0;
      zc_q    <= '0;
      fault_q <= '0;
    end else begin
      vn_q <= {Vcn, Vbn, Van};
      for (int i = 0; i < 3; i++) begin
        if (v_q[i] && vn_q[i]) begin
          fault_q[i] <= 1'b1;
        end
        if (!v_q[i] && !vn_q[i]) begin
          if (zc_q[i] == ZcLast) begin
            fault_q[i] <= 1'b1;
          end else begin
            zc_q[i] <= zc_q[i] + 1'b1;
          end
        end else begin
          zc_q[i] <= '0;
        end
      end
    end
  end

  assign fault = fault_q;
`else
  logic unused_vn;
  assign unused_vn = ^{Van, Vbn, Vcn};
  assign fault     = 3'b000;
`endif

endmodule
